// File: rtl/aes_round_sequencer_if.sv
// Valid/ready block stream carrying one 128-bit AES block (byte 0 in [127:120]).
// The producer uses the master modport and the consumer uses the slave modport.
interface aes_round_sequencer_if;
   logic         valid;
   logic         ready;
   logic [127:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: owns the cipher state and steps an external round datapath.
// Build option AES_SEQ_ZEROIZE_EN clears the state register when a ciphertext is handed off.
module aes_round_sequencer #(
   parameter int NR  = 10,
   parameter int RKW = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   aes_round_sequencer_if.slave  in_if,
   aes_round_sequencer_if.master out_if,
   output logic [RKW-1:0]      rk_idx,
   input  logic [127:0]        rk,
   output logic [127:0]        dp_state,
   output logic                dp_final,
   input  logic [127:0]        dp_result,
   output logic                busy
);

   localparam logic [RKW-1:0] LAST = RKW'(NR);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

   fsm_t           fsm;
   logic [RKW-1:0] round;
   logic [127:0]   state;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           busy_q;
   logic           dp_final_q;

   // All control outputs are registered. The round counter doubles as the key index,
   // so it sits at 0 outside ROUND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= S_IDLE;
         round       <= '0;
         state       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         dp_final_q  <= 1'b0;
      end else begin
         case (fsm)
            S_IDLE: begin
               if (in_if.valid) begin
                  state      <= in_if.data ^ rk;
                  round      <= RKW'(1);
                  fsm        <= S_ROUND;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  dp_final_q <= 1'b0;
               end
            end
            S_ROUND: begin
               state <= dp_result;
               if (round == LAST) begin
                  round       <= '0;
                  fsm         <= S_DONE;
                  out_valid_q <= 1'b1;
                  dp_final_q  <= 1'b0;
               end else begin
                  round      <= round + RKW'(1);
                  dp_final_q <= ((round + RKW'(1)) == LAST);
               end
            end
            S_DONE: begin
               if (out_if.ready) begin
                  fsm         <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
`ifdef AES_SEQ_ZEROIZE_EN
                  state       <= '0;
`else
                  state       <= state;
`endif
               end
            end
            default: begin
               fsm         <= S_IDLE;
               round       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               dp_final_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_if.ready  = in_ready_q;
   assign out_if.valid = out_valid_q;
   assign out_if.data  = state;
   assign rk_idx       = round;
   assign dp_state     = state;
   assign dp_final     = dp_final_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: it supplies an AES-128 round datapath and a key store,
// and it checks the sequencer against a cycle-level scoreboard plus the FIPS-197 C.1 vector.
module tb_aes_round_sequencer;
   localparam int NR  = 10;
   localparam int RKW = 4;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic           clk;
   logic           rst_n;
   logic [RKW-1:0] rk_idx;
   logic [127:0]   rk;
   logic [127:0]   dp_state;
   logic           dp_final;
   logic [127:0]   dp_result;
   logic           busy;

   aes_round_sequencer_if in_if ();
   aes_round_sequencer_if out_if ();

   aes_round_sequencer #(.NR(NR), .RKW(RKW)) dut (
      .clk(clk), .rst_n(rst_n), .in_if(in_if), .out_if(out_if),
      .rk_idx(rk_idx), .rk(rk), .dp_state(dp_state), .dp_final(dp_final),
      .dp_result(dp_result), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254, then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] y, r;
      y = gm(x, x); r = y;
      for (int i = 0; i < 6; i++) begin
         y = gm(y, y);
         r = gm(r, y);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[4*c+r] = a[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         if (fin) begin
            for (int r = 0; r < 4; r++) m[4*c+r] = t[4*c+r];
         end else begin
            m[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
            m[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
      return o ^ k;
   endfunction

   logic [127:0] rks [NR+1];
   logic [31:0]  w   [4*(NR+1)];

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 4*(NR+1); i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox(tmp[31:24]) ^ rc, sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ rks[0];
      for (int r = 1; r <= NR; r++) s = aes_round(s, rks[r], r == NR);
      return s;
   endfunction

   // Bench-side key store and round datapath the sequencer drives.
   always_comb rk = rks[rk_idx];
   always_comb dp_result = aes_round(dp_state, rk, dp_final);

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Scoreboard: at most one block in flight; timing counted from the accept cycle.
   int           cyc      = 0;
   int           acc_cyc  = 0;
   int           last_acc = -1;
   bit           inflight = 1'b0;
   bit           b2b      = 1'b0;
   logic [127:0] exp_ct   = '0;
   logic [127:0] idle_exp = '0;

   task automatic model_reset();
      inflight = 1'b0;
      idle_exp = '0;
      last_acc = -1;
   endtask

   task automatic step(input bit v, input logic [127:0] d, input bit r);
      int k;
      @(negedge clk);
      in_if.valid  = v;
      in_if.data   = d;
      out_if.ready = r;
      #1;
      cyc++;
      k = cyc - acc_cyc;
      chk("in_ready",  in_if.ready,  !inflight);
      chk("busy",      busy,         inflight);
      chk("out_valid", out_if.valid, inflight && k > NR);
      chk("rk_idx",    rk_idx,       (inflight && k <= NR) ? k : 0);
      chk("dp_final",  dp_final,     inflight && k == NR);
      if (inflight && k > NR) chk("out_block", out_if.data, exp_ct);
      if (!inflight) chk("idle_state", dp_state, idle_exp);
      if (inflight && k > NR && r) begin
         inflight = 1'b0;
`ifdef AES_SEQ_ZEROIZE_EN
         idle_exp = '0;
`else
         idle_exp = exp_ct;
`endif
      end else if (!inflight && v) begin
         if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, NR + 2);
         inflight = 1'b1;
         acc_cyc  = cyc;
         last_acc = cyc;
         exp_ct   = aes_ref(d);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      bit found;
      rst_n        = 1'b0;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b0;
      expand_key(FIPS_KEY);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_if.valid, 0);
      chk("rst_busy",      busy,         0);
      chk("rst_rk_idx",    rk_idx,       0);
      chk("rst_dp_final",  dp_final,     0);
      chk("rst_dp_state",  dp_state,     0);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_in_ready", in_if.ready, 1);

      // Idle with no offer: nothing moves
      repeat (3) step(1'b0, rnd128(), 1'b0);

      // FIPS vector, then 20 cycles of backpressure with ignored in_valid pulses
      step(1'b1, FIPS_PT, 1'b0);
      repeat (NR + 1) step(1'b0, rnd128(), 1'b0);
      chk("fips_ct", out_if.data, FIPS_CT);
      repeat (20) step(1'($urandom_range(0, 1)), rnd128(), 1'b0);
      step(1'b0, '0, 1'b1);
      repeat (4) step(1'b0, rnd128(), 1'b0);

      // Reset while the round counter is at 5
      step(1'b1, rnd128(), 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, rnd128(), 1'b0);
         if (rk_idx == RKW'(5)) found = 1'b1;
      end
      chk("reach_rk5", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy",      busy,         0);
      chk("midrst_out_valid", out_if.valid, 0);
      chk("midrst_rk_idx",    rk_idx,       0);
      chk("midrst_dp_state",  dp_state,     0);
      chk("midrst_dp_final",  dp_final,     0);
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      step(1'b1, FIPS_PT, 1'b0);
      repeat (NR + 1) step(1'b0, rnd128(), 1'b0);
      chk("fips_ct_after_rst", out_if.data, FIPS_CT);
      step(1'b0, '0, 1'b1);

      // Back-to-back: in_valid held high, sink always ready
      b2b = 1'b1; last_acc = -1;
      repeat (5 * (NR + 2)) step(1'b1, rnd128(), 1'b1);
      b2b = 1'b0;
      repeat (NR + 3) step(1'b0, '0, 1'b1);

      // Randomized traffic and backpressure
      repeat (1500) step(1'($urandom_range(0, 2) != 0), rnd128(), 1'($urandom_range(0, 1)));
      repeat (NR + 3) step(1'b0, '0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES encryption controller. It owns the 128-bit cipher state register and sequences one external round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) once per cycle.
- It drives the round-key index to the key store, asserts the final-round bypass of MixColumns on the last round, and presents the ciphertext through a valid/ready output handshake.
- It sits between the block-input interface and the output buffer of the AES core.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- RKW, 4, width of the round-key index; must satisfy 2^RKW > NR.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  sequencer can accept a block.
- in_block  input  128  plaintext, byte 0 in [127:120].
- rk_idx  output  RKW  round-key index requested from the key store.
- rk  input  128  round key for rk_idx, valid combinationally in the same cycle.
- dp_state  output  128  current state register, fed to the round datapath.
- dp_final  output  1  final-round flag to the datapath; 1 = skip MixColumns.
- dp_result  input  128  combinational round output (includes AddRoundKey with rk).
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  downstream accepts ciphertext.
- out_block  output  128  ciphertext; equals dp_state while in DONE.
- busy  output  1  high in ROUND or DONE.

Behaviour:
- FSM states:
  - IDLE: in_ready=1, rk_idx=0. On in_valid: state <= in_block ^ rk (initial AddRoundKey), round <= 1, go to ROUND.
  - ROUND: rk_idx=round, dp_final=(round==NR). Each cycle: state <= dp_result and round <= round+1. When round==NR, load the last result and go to DONE.
  - DONE: out_valid=1, out_block=state. Stay until out_ready; on out_valid&&out_ready go to IDLE.
- Latency:
  - Accept edge T; out_valid rises after edge T+NR (T+10 for AES-128).
  - Throughput is one block per NR+2 cycles; the IDLE bubble is mandatory.
- Output stability: out_block and out_valid are held stable while out_valid=1 && !out_ready. No output changes without a handshake.
- Input gating: in_ready is 0 in ROUND and DONE. in_valid in those states is ignored and does not alter state.
- dp_final is 0 in IDLE and DONE, and 1 only in the ROUND cycle with round==NR.
- Round counter:
  - Width RKW; counts 1..NR and never wraps.
  - In IDLE and DONE, rk_idx is 0 and the counter is held at 0.
- Reset values (rst_n low, any state, asynchronous, including mid-round):
  - FSM=IDLE, round=0, state=128'h0.
  - in_ready=1 after the release edge; out_valid=0, busy=0, dp_final=0, rk_idx=0.
  - An in-flight block is discarded with no partial output.
- Simultaneous events:
  - out_ready asserted on the same edge out_valid rises: the handshake completes on the next edge, because out_valid is registered-state driven.
  - in_valid held high through DONE: accepted on the first IDLE cycle only.
- Zero-length or idle: with no in_valid, the FSM stays in IDLE indefinitely and state is unchanged.

Optional Feature:
- Macro: AES_SEQ_ZEROIZE_EN.
- Defined: on the DONE->IDLE handshake edge, the state register is cleared to 128'h0, so no ciphertext or intermediate remains resident after delivery. dp_state reads 0 in IDLE.
- Undefined: the state register retains the last ciphertext in IDLE until the next accept overwrites it. There is no extra logic.

Test Plan:
- FIPS-197 C.1 test vector:
  - Stimulus: NR=10, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, bench round model + key store.
  - Required response: out_block=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after the accept edge.
- Sequencing check:
  - Stimulus: one block.
  - Required response: rk_idx steps 0,1,...,10 on consecutive cycles. dp_final=1 only on the rk_idx=10 cycle and 0 on the other 10 cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid.
  - Required response: out_block stable, in_ready=0 throughout, and in_valid pulses ignored. Release out_ready: handshake completes in 1 cycle, then in_ready=1 the next cycle.
- Reset mid-operation:
  - Stimulus: drop rst_n at rk_idx=5.
  - Required response: immediately busy=0, out_valid=0, rk_idx=0, dp_state=0. After release, a new FIPS block completes correctly.
- Back-to-back blocks:
  - Stimulus: in_valid held high, out_ready=1.
  - Required response: accepts spaced exactly 12 cycles apart for NR=10; each ciphertext is correct.
- AES_SEQ_ZEROIZE_EN:
  - Defined: dp_state=0 the cycle after output handshake.
  - Undefined: dp_state equals the last ciphertext until the next accept.
